vfetch: RTL and testbench

VFETCH -- requirements
Module: vfetch

---
 rtl/vga_pkg.sv | 13 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/vfetch.sv | 121 ++++++++++++
 tb/tb_vfetch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA fetch constants and the in-flight tag encoding.
package vga_pkg;
    localparam int AWIDTH     = 19;
    localparam int DWIDTH     = 8;
    localparam int BASEADDR   = 0;
    localparam int FRAMEBYTES = 307200;
    localparam int TAGDEPTH   = 4;

    typedef enum logic {
        TAG_DROP = 1'b0,
        TAG_KEEP = 1'b1
    } tag_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output and occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPop;
    logic             full;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign doPop = pop && !empty;
    assign dout  = mem[rdPtr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wrPtr] <= din;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(push) - CW'(doPop);
        end
    end

    // Space is reserved upstream before a read is issued, so a full push is a bug.
    noFullPush: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !clear));
endmodule

// File: rtl/vfetch.sv
// Frame fetcher: issues sequential reads, tags each acked request and
// buffers kept return bytes for the pixel consumer.
module vfetch import vga_pkg::*; #(
    parameter int AWIDTH     = vga_pkg::AWIDTH,
    parameter int DWIDTH     = vga_pkg::DWIDTH,
    parameter int DEPTH      = 16,
    parameter int BASEADDR   = vga_pkg::BASEADDR,
    parameter int FRAMEBYTES = vga_pkg::FRAMEBYTES
) (
    input  logic              MemClk,
    input  logic              Reset,
    input  logic              FrameStart,
    output logic [AWIDTH-1:0] ReqAddr,
    input  logic              AddrAck,
    input  logic [DWIDTH-1:0] ReadData,
    input  logic              ReadDataRdy,
    input  logic              PixelReq,
    output logic [DWIDTH-1:0] PixelData,
    output logic              PixelValid,
    output logic              Underrun,
    output logic              TagError
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TAGDEPTH);
    localparam logic [AWIDTH-1:0] FIRST = AWIDTH'(BASEADDR);
    localparam logic [AWIDTH-1:0] LAST  = AWIDTH'(BASEADDR + FRAMEBYTES - 1);

    tag_t          tagMem [TAGDEPTH];
    logic [TW-1:0] tagWr;
    logic [TW-1:0] tagRd;
    logic [TW:0]   tagCnt;
    logic [CW-1:0] resInflight;
    logic [CW-1:0] pixCount;
    logic [CW:0]   used;
    logic          pixEmpty;

    logic tagFull;
    logic tagEmpty;
    logic ackTake;
    logic retTake;
    logic hasSpace;
    logic keepAck;
    logic headKeep;
    logic pixPush;
    logic resRelease;
    tag_t newTag;

    assign tagFull    = (tagCnt == (TW+1)'(TAGDEPTH));
    assign tagEmpty   = (tagCnt == '0);
    assign ackTake    = AddrAck && !tagFull;
    assign retTake    = ReadDataRdy && !tagEmpty;
    assign used       = {1'b0, pixCount} + {1'b0, resInflight};
    assign hasSpace   = (used < (CW+1)'(DEPTH));
    assign keepAck    = ackTake && hasSpace && !FrameStart;
    assign newTag     = keepAck ? TAG_KEEP : TAG_DROP;
    assign headKeep   = (tagMem[tagRd] == TAG_KEEP);
    assign pixPush    = retTake && headKeep && !FrameStart;
    assign resRelease = retTake && headKeep;
    assign PixelValid = !pixEmpty;

    sync_fifo #(
        .WIDTH (DWIDTH),
        .DEPTH (DEPTH)
    ) pixFifo (
        .clk   (MemClk),
        .rst   (Reset),
        .clear (FrameStart),
        .push  (pixPush),
        .din   (ReadData),
        .pop   (PixelReq && !FrameStart),
        .dout  (PixelData),
        .empty (pixEmpty),
        .count (pixCount)
    );

    // A frame restart turns every outstanding return into a discard.
    always_ff @(posedge MemClk or posedge Reset) begin
        if (Reset) begin
            tagWr  <= '0;
            tagRd  <= '0;
            tagCnt <= '0;
            for (int i = 0; i < TAGDEPTH; i++) tagMem[i] <= TAG_DROP;
        end else begin
            if (FrameStart)
                for (int i = 0; i < TAGDEPTH; i++) tagMem[i] <= TAG_DROP;
            if (ackTake) begin
                tagMem[tagWr] <= newTag;
                tagWr         <= tagWr + 1'b1;
            end
            if (retTake) tagRd <= tagRd + 1'b1;
            tagCnt <= tagCnt + (TW+1)'(ackTake) - (TW+1)'(retTake);
        end
    end

    always_ff @(posedge MemClk or posedge Reset) begin
        if (Reset) begin
            resInflight <= '0;
            ReqAddr     <= FIRST;
        end else if (FrameStart) begin
            resInflight <= '0;
            ReqAddr     <= FIRST;
        end else begin
            resInflight <= resInflight + CW'(keepAck) - CW'(resRelease);
            if (keepAck) ReqAddr <= (ReqAddr == LAST) ? FIRST : ReqAddr + 1'b1;
        end
    end

    always_ff @(posedge MemClk or posedge Reset) begin
        if (Reset) begin
            Underrun <= 1'b0;
            TagError <= 1'b0;
        end else begin
            if (FrameStart)
                Underrun <= 1'b0;
            else if (PixelReq && pixEmpty)
                Underrun <= 1'b1;
            if ((AddrAck && tagFull) || (ReadDataRdy && tagEmpty))
                TagError <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vfetch.sv
// Self-checking bench for vfetch with a byte scoreboard.
module tb_vfetch;
    localparam int AW   = 19;
    localparam int BASE = 32;
    localparam int FB   = 24;

    logic          MemClk = 1'b0;
    logic          Reset;
    logic          FrameStart;
    logic [AW-1:0] ReqAddr;
    logic          AddrAck;
    logic [7:0]    ReadData;
    logic          ReadDataRdy;
    logic          PixelReq;
    logic [7:0]    PixelData;
    logic          PixelValid;
    logic          Underrun;
    logic          TagError;

    int tests  = 0;
    int failed = 0;
    logic [7:0] sb [$];

    typedef struct {
        logic [7:0] data;
        int         expAddr;
    } vec_t;
    vec_t vecs [3];

    vfetch #(
        .AWIDTH     (AW),
        .DWIDTH     (8),
        .DEPTH      (16),
        .BASEADDR   (BASE),
        .FRAMEBYTES (FB)
    ) dut (
        .MemClk      (MemClk),
        .Reset       (Reset),
        .FrameStart  (FrameStart),
        .ReqAddr     (ReqAddr),
        .AddrAck     (AddrAck),
        .ReadData    (ReadData),
        .ReadDataRdy (ReadDataRdy),
        .PixelReq    (PixelReq),
        .PixelData   (PixelData),
        .PixelValid  (PixelValid),
        .Underrun    (Underrun),
        .TagError    (TagError)
    );

    always #5 MemClk = ~MemClk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic a, input logic r, input logic [7:0] d,
                        input logic p, input logic f);
        AddrAck     = a;
        ReadDataRdy = r;
        ReadData    = d;
        PixelReq    = p;
        FrameStart  = f;
        @(posedge MemClk);
        #1;
        AddrAck     = 1'b0;
        ReadDataRdy = 1'b0;
        ReadData    = '0;
        PixelReq    = 1'b0;
        FrameStart  = 1'b0;
    endtask

    task automatic ack();
        step(1, 0, 8'h00, 0, 0);
    endtask

    task automatic ret(input logic [7:0] d, input logic keep);
        if (keep) sb.push_back(d);
        step(0, 1, d, 0, 0);
    endtask

    task automatic popChk(input string nm);
        chk({nm, "_valid"}, 32'(PixelValid), 1);
        if (sb.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL %s: scoreboard empty, dut shows %0h", nm, PixelData);
        end else begin
            chk(nm, 32'(PixelData), 32'(sb.pop_front()));
        end
        step(0, 0, 8'h00, 1, 0);
    endtask

    // Return a byte and pop the head in the same cycle.
    task automatic retPop(input string nm, input logic [7:0] d);
        chk({nm, "_valid"}, 32'(PixelValid), 1);
        if (sb.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL %s: scoreboard empty, dut shows %0h", nm, PixelData);
        end else begin
            chk(nm, 32'(PixelData), 32'(sb.pop_front()));
        end
        sb.push_back(d);
        step(0, 1, d, 1, 0);
    endtask

    initial begin
        vecs[0] = '{data: 8'h11, expAddr: BASE + 1};
        vecs[1] = '{data: 8'h22, expAddr: BASE + 2};
        vecs[2] = '{data: 8'h33, expAddr: BASE + 3};

        Reset = 1'b1;
        FrameStart = 0; AddrAck = 0; ReadData = 0;
        ReadDataRdy = 0; PixelReq = 0;
        repeat (2) @(posedge MemClk);
        #1;
        chk("rst_addr", 32'(ReqAddr), BASE);
        chk("rst_valid", 32'(PixelValid), 0);
        chk("rst_data", 32'(PixelData), 0);
        chk("rst_underrun", 32'(Underrun), 0);
        chk("rst_tagerr", 32'(TagError), 0);
        Reset = 1'b0;

        // Basic in-order fetch
        for (int i = 0; i < 3; i++) begin
            ack();
            chk($sformatf("seq_addr%0d", i), 32'(ReqAddr), 32'(vecs[i].expAddr));
            ret(vecs[i].data, 1'b1);
            chk($sformatf("seq_valid%0d", i), 32'(PixelValid), 1);
        end
        for (int i = 0; i < 3; i++) popChk($sformatf("seq_pop%0d", i));
        chk("seq_empty", 32'(PixelValid), 0);

        // Underrun is sticky
        step(0, 0, 8'h00, 1, 0);
        chk("urun_set", 32'(Underrun), 1);
        chk("urun_valid", 32'(PixelValid), 0);
        step(0, 0, 8'h00, 0, 0);
        chk("urun_hold", 32'(Underrun), 1);

        // FrameStart with 5 buffered and 2 outstanding, plus a coincident ack
        for (int i = 0; i < 5; i++) begin
            ack();
            ret(8'(8'h40 + i), 1'b1);
        end
        ack();
        ack();
        chk("fs_pre_urun", 32'(Underrun), 1);
        chk("fs_pre_valid", 32'(PixelValid), 1);
        step(1, 0, 8'h00, 0, 1);
        sb.delete();
        chk("fs_valid", 32'(PixelValid), 0);
        chk("fs_addr", 32'(ReqAddr), BASE);
        chk("fs_urun", 32'(Underrun), 0);
        ret(8'h77, 1'b0);
        ret(8'h88, 1'b0);
        ret(8'h99, 1'b0);
        chk("fs_late_valid", 32'(PixelValid), 0);
        chk("fs_tagerr", 32'(TagError), 0);
        ack();
        chk("fs_next_addr", 32'(ReqAddr), BASE + 1);
        ret(8'h5A, 1'b1);
        popChk("fs_next_pop");

        // Reservation limit: 14 buffered + 2 in flight fills 16 slots
        step(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 14; i++) begin
            ack();
            ret(8'(i + 1), 1'b1);
        end
        ack();
        ack();
        chk("full_addr16", 32'(ReqAddr), BASE + 16);
        ack();
        chk("full_hold", 32'(ReqAddr), BASE + 16);
        ret(8'hA1, 1'b1);
        ret(8'hA2, 1'b1);
        ret(8'hEE, 1'b0);
        for (int i = 0; i < 16; i++) popChk($sformatf("full_pop%0d", i));
        chk("full_drained", 32'(PixelValid), 0);
        chk("full_tagerr", 32'(TagError), 0);

        // Address wrap with same-cycle push and pop
        step(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < FB; i++) begin
            chk($sformatf("wrap_addr%0d", i), 32'(ReqAddr), 32'(BASE + i));
            ack();
            if (i == 0) ret(8'h03, 1'b1);
            else retPop($sformatf("wrap_pop%0d", i), 8'(i * 7 + 3));
        end
        chk("wrap_base", 32'(ReqAddr), BASE);
        popChk("wrap_last");
        chk("wrap_empty", 32'(PixelValid), 0);

        // Tag FIFO overflow
        for (int i = 0; i < 4; i++) ack();
        chk("tag_addr4", 32'(ReqAddr), BASE + 4);
        chk("tag_noerr", 32'(TagError), 0);
        ack();
        chk("tag_err", 32'(TagError), 1);
        chk("tag_hold", 32'(ReqAddr), BASE + 4);
        for (int i = 0; i < 4; i++) ret(8'(8'hC0 + i), 1'b1);
        for (int i = 0; i < 4; i++) popChk($sformatf("tag_pop%0d", i));
        chk("tag_sticky", 32'(TagError), 1);

        // Reset mid-run, then a return with no outstanding tag
        Reset = 1'b1;
        #2;
        chk("arst_tagerr", 32'(TagError), 0);
        chk("arst_addr", 32'(ReqAddr), BASE);
        @(posedge MemClk);
        #1;
        Reset = 1'b0;
        ack();
        chk("arst_first_ack", 32'(ReqAddr), BASE + 1);
        ret(8'h3C, 1'b1);
        step(0, 1, 8'h99, 0, 0);
        chk("orphan_tagerr", 32'(TagError), 1);
        popChk("arst_pop");
        chk("arst_empty", 32'(PixelValid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
